// File: rtl/deserializer.sv
// Serial-to-parallel receiver for a 16-bit MSB-first stream framed as SYNC_WORD + payload.
// Hunts bit-by-bit for the sync pattern, then emits each payload word and tracks consecutive sync misses.
module deserializer #(
  parameter int                   WIDTH     = 16,
  parameter logic [WIDTH-1:0]     SYNC_WORD = 16'hA5C3,
  parameter int                   MISS_MAX  = 3,
  parameter int                   ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    MISS_LIMIT = 4'(MISS_MAX);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t           state;
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic [3:0]       miss;
  logic [WIDTH-1:0] win;
  logic [3:0]       miss_inc;

  // Only WIDTH-1 history bits are kept; the current input completes the window.
  assign win      = {sr, in};
  assign miss_inc = miss + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      sr       <= '0;
      cnt      <= '0;
      miss     <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      sr    <= win[WIDTH-2:0];
      valid <= 1'b0;
      case (state)
        HUNT: begin
          if (win == SYNC_WORD) begin
            state  <= PAYLOAD;
            cnt    <= '0;
            locked <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (cnt == LAST) begin
            data_out <= win;
            valid    <= 1'b1;
            cnt      <= '0;
            state    <= CHECK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CHECK: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (win == SYNC_WORD) begin
              miss  <= '0;
              state <= PAYLOAD;
            end else begin
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
              // Too many consecutive misses: give up alignment and slide again from the next bit.
              if (miss_inc == MISS_LIMIT) begin
                miss   <= '0;
                state  <= HUNT;
                locked <= 1'b0;
              end else begin
                miss  <= miss_inc;
                state <= PAYLOAD;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer: default instance plus a small-counter instance for saturation.
module tb_deserializer;

  logic        clk;
  logic        rst_n;
  logic        in;
  logic [15:0] data_out;
  logic        valid;
  logic        locked;
  logic [7:0]  err_cnt;
  logic [15:0] data_out2;
  logic        valid2;
  logic        locked2;
  logic [1:0]  err_cnt2;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int vbase  = 0;

  deserializer dut (
    .clk(clk), .rst_n(rst_n), .in(in),
    .data_out(data_out), .valid(valid), .locked(locked), .err_cnt(err_cnt)
  );

  deserializer #(.WIDTH(16), .SYNC_WORD(16'hA5C3), .MISS_MAX(15), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(in),
    .data_out(data_out2), .valid(valid2), .locked(locked2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
  endtask

  // One bit per clock; outputs are sampled 1 time unit after the edge that consumed the bit.
  task automatic sendBit(input logic b);
    in = b;
    @(posedge clk);
    #1;
    if (valid === 1'b1) vcount++;
  endtask

  task automatic sendBits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(w[i]);
  endtask

  task automatic sendWord(input logic [15:0] w);
    sendBits({16'h0, w}, 16);
  endtask

  task automatic applyStimulus(input logic [15:0] w, input logic [15:0] expData, input string name);
    sendWord(w);
    checkOutput({name, "_valid"}, {31'h0, valid}, 32'h1);
    checkOutput({name, "_data"}, {16'h0, data_out}, {16'h0, expData});
  endtask

  task automatic doReset();
    in = 1'b0;
    rst_n = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vcount = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    in    = 1'b0;
    #2;

    // Reset state
    doReset();
    checkOutput("rst_data", {16'h0, data_out}, 32'h0);
    checkOutput("rst_valid", {31'h0, valid}, 32'h0);
    checkOutput("rst_locked", {31'h0, locked}, 32'h0);
    checkOutput("rst_err", {24'h0, err_cnt}, 32'h0);

    // Aligned lock
    sendBits(32'hA5C3 >> 1, 15);
    checkOutput("al_prelock", {31'h0, locked}, 32'h0);
    sendBit(1'b1);
    checkOutput("al_lock", {31'h0, locked}, 32'h1);
    applyStimulus(16'h1234, 16'h1234, "al_p1");
    sendWord(16'hA5C3);
    checkOutput("al_valid_in_check", {31'h0, valid}, 32'h0);
    applyStimulus(16'hBEEF, 16'hBEEF, "al_p2");
    sendBit(1'b1);
    checkOutput("al_pulse_len", {31'h0, valid}, 32'h0);
    checkOutput("al_vcount", vcount, 32'd2);
    checkOutput("al_err", {24'h0, err_cnt}, 32'h0);

    // Misaligned start
    doReset();
    sendBits(32'b10110, 5);
    sendBits(32'hA5C3 >> 1, 15);
    checkOutput("mis_prelock", {31'h0, locked}, 32'h0);
    sendBit(1'b1);
    checkOutput("mis_lock", {31'h0, locked}, 32'h1);
    applyStimulus(16'h0F0F, 16'h0F0F, "mis_p1");
    sendWord(16'hA5C3);
    applyStimulus(16'h00FF, 16'h00FF, "mis_p2");
    checkOutput("mis_vcount", vcount, 32'd2);
    checkOutput("mis_err", {24'h0, err_cnt}, 32'h0);

    // Single miss tolerated, and a matching sync clears the miss count
    doReset();
    sendWord(16'hA5C3);
    applyStimulus(16'h1111, 16'h1111, "sm_p1");
    sendWord(16'h0000);
    checkOutput("sm_err1", {24'h0, err_cnt}, 32'd1);
    checkOutput("sm_lock1", {31'h0, locked}, 32'h1);
    applyStimulus(16'h2222, 16'h2222, "sm_p2");
    sendWord(16'hA5C3);
    checkOutput("sm_err_hold", {24'h0, err_cnt}, 32'd1);
    applyStimulus(16'h3333, 16'h3333, "sm_p3");
    sendWord(16'h0000);
    applyStimulus(16'h5555, 16'h5555, "sm_p4");
    sendWord(16'h0000);
    checkOutput("sm_err3", {24'h0, err_cnt}, 32'd3);
    checkOutput("sm_lock_kept", {31'h0, locked}, 32'h1);
    applyStimulus(16'h6666, 16'h6666, "sm_p5");

    // Loss of lock after three consecutive misses, then re-lock
    doReset();
    sendWord(16'hA5C3);
    applyStimulus(16'hAAAA, 16'hAAAA, "ll_p1");
    sendWord(16'h0000);
    applyStimulus(16'h1357, 16'h1357, "ll_p2");
    sendWord(16'h0000);
    applyStimulus(16'h2468, 16'h2468, "ll_p3");
    sendBits(32'h0, 15);
    checkOutput("ll_lock_before", {31'h0, locked}, 32'h1);
    sendBit(1'b0);
    checkOutput("ll_lock_drop", {31'h0, locked}, 32'h0);
    checkOutput("ll_err", {24'h0, err_cnt}, 32'd3);
    vbase = vcount;
    sendWord(16'hA5C3);
    checkOutput("ll_relock", {31'h0, locked}, 32'h1);
    checkOutput("ll_no_valid_hunt", vcount, vbase);
    applyStimulus(16'h9999, 16'h9999, "ll_p4");

    // Asynchronous reset in the middle of a payload word
    doReset();
    sendWord(16'hA5C3);
    applyStimulus(16'h7777, 16'h7777, "mr_p1");
    sendWord(16'hA5C3);
    sendBits(32'hFF, 8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_data", {16'h0, data_out}, 32'h0);
    checkOutput("mr_locked", {31'h0, locked}, 32'h0);
    checkOutput("mr_valid", {31'h0, valid}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vcount = 0;
    sendBits(32'hFF, 8);
    sendBits(32'h0, 16);
    checkOutput("mr_no_valid", vcount, 32'd0);
    checkOutput("mr_hunt", {31'h0, locked}, 32'h0);
    sendWord(16'hA5C3);
    applyStimulus(16'hABCD, 16'hABCD, "mr_p2");

    // Saturating error counter on the ERR_W=2, MISS_MAX=15 instance
    doReset();
    sendWord(16'hA5C3);
    checkOutput("sat_lock", {31'h0, locked2}, 32'h1);
    for (int k = 1; k <= 15; k++) begin
      sendBits(32'h0, 32);
      checkOutput($sformatf("sat_err_%0d", k), {30'h0, err_cnt2}, (k < 3) ? k : 3);
      checkOutput($sformatf("sat_lock_%0d", k), {31'h0, locked2}, (k < 15) ? 32'h1 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
